// File: rtl/icmp_pkg.sv
// Shared ICMP constants, sequencer state encoding and one's-complement helper
// used by the byte-serial ICMP transmit path.
package icmp_pkg;

    localparam logic [7:0] ICMP_ECHO_REQ   = 8'd8;
    localparam logic [7:0] ICMP_ECHO_REPLY = 8'd0;
    localparam int         ICMP_HDR_BYTES  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } seq_state_e;

    // 16-bit one's-complement add with a single end-around carry
    function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/icmp_cksum_adjust.sv
// Incremental Internet checksum update (RFC 1624): HC' = ~(~HC + ~m + m'),
// where m/m' are the old and new values of one 16-bit header word.
module icmp_cksum_adjust
    import icmp_pkg::*;
(
    input  logic [15:0] cksum_i,
    input  logic [15:0] old_word_i,
    input  logic [15:0] new_word_i,
    output logic [15:0] cksum_o
);

    // Pure combinational update of the one's-complement checksum
    always_comb begin
        cksum_o = ~ones_add16(ones_add16(~cksum_i, ~old_word_i), new_word_i);
    end

endmodule

// File: rtl/icmp_tx_sequencer8.sv
// Drives one external byte-serial ICMP encoder per accepted request and presents
// its output as a ready/valid byte stream with start/end-of-packet markers.
module icmp_tx_sequencer8
    import icmp_pkg::*;
#(
    parameter int LEN_W     = 11,
    parameter int BYTE_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_reply_mode,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_type,
    input  logic [7:0]           req_code,
    input  logic [15:0]          req_checksum,
    input  logic [LEN_W-1:0]     req_len,
    output logic [LEN_W-1:0]     pl_rd_addr,
    input  logic [BYTE_SIZE-1:0] pl_rd_data,
    output logic                 enc_sync_reset,
    output logic                 enc_run,
    output logic [7:0]           enc_type,
    output logic [7:0]           enc_code,
    output logic [15:0]          enc_checksum,
    output logic [BYTE_SIZE-1:0] enc_data_in,
    input  logic [BYTE_SIZE-1:0] enc_data_out,
    output logic [BYTE_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    output logic                 tx_sop,
    output logic                 tx_eop,
    input  logic                 tx_ready,
    output logic                 req_err
);

    localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(ICMP_HDR_BYTES);
    localparam logic [LEN_W:0]   HDR_LAST = (LEN_W+1)'(ICMP_HDR_BYTES - 1);

    seq_state_e         state_q, state_d;
    logic               req_ready_q, req_ready_d;
    logic               req_err_q, req_err_d;
    logic               sync_q, sync_d;
    logic               valid_q, valid_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic [7:0]         type_q, type_d;
    logic [7:0]         code_q, code_d;
    logic [15:0]        cksum_q, cksum_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W:0]     byte_cnt_q, byte_cnt_d;
    logic [LEN_W:0]     pl_idx_q, pl_idx_d;

    logic               run_s;
    logic               accept_s;
    logic               to_reply_s;
    logic [15:0]        adj_cksum_s;
    logic [LEN_W:0]     last_idx_s;

    // The code byte is carried over unchanged, so only the type contributes to the update
    icmp_cksum_adjust u_cksum_adjust (
        .cksum_i    (req_checksum),
        .old_word_i ({ICMP_ECHO_REQ, 8'h00}),
        .new_word_i ({ICMP_ECHO_REPLY, 8'h00}),
        .cksum_o    (adj_cksum_s)
    );

    assign run_s      = valid_q & tx_ready;
    assign accept_s   = req_valid & req_ready_q;
    assign to_reply_s = cfg_reply_mode & (req_type == ICMP_ECHO_REQ);
    assign last_idx_s = {1'b0, len_q} + HDR_LAST;

    // Next-state and next-output computation for the request/stream sequencer
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        req_err_d   = 1'b0;
        sync_d      = 1'b0;
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        type_d      = type_q;
        code_d      = code_q;
        cksum_d     = cksum_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        pl_idx_d    = pl_idx_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                valid_d     = 1'b0;
                sop_d       = 1'b0;
                eop_d       = 1'b0;
                if (accept_s) begin
                    if (req_len < MIN_LEN) begin
                        req_err_d = 1'b1;
                    end else begin
                        state_d     = LOAD;
                        req_ready_d = 1'b0;
                        sync_d      = 1'b1;
                        type_d      = to_reply_s ? ICMP_ECHO_REPLY : req_type;
                        code_d      = req_code;
                        cksum_d     = to_reply_s ? adj_cksum_s : req_checksum;
                        len_d       = req_len;
                        byte_cnt_d  = '0;
                        pl_idx_d    = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d     = STREAM;
                req_ready_d = 1'b0;
                byte_cnt_d  = '0;
                pl_idx_d    = '0;
                valid_d     = 1'b1;
                sop_d       = 1'b1;
                eop_d       = 1'b0;
            end
            STREAM: begin
                if (run_s) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    pl_idx_d   = pl_idx_q + 1'b1;
                    sop_d      = 1'b0;
                    if (eop_q) begin
                        state_d     = IDLE;
                        req_ready_d = 1'b1;
                        valid_d     = 1'b0;
                        eop_d       = 1'b0;
                    end else begin
                        eop_d = (byte_cnt_d == last_idx_s);
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b0;
                valid_d     = 1'b0;
                sop_d       = 1'b0;
                eop_d       = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset abandons any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            req_err_q   <= 1'b0;
            sync_q      <= 1'b0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            type_q      <= 8'h00;
            code_q      <= 8'h00;
            cksum_q     <= 16'h0000;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            pl_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            req_err_q   <= req_err_d;
            sync_q      <= sync_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            type_q      <= type_d;
            code_q      <= code_d;
            cksum_q     <= cksum_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            pl_idx_q    <= pl_idx_d;
        end
    end

    // Look-ahead read address so pl_rd_data always holds payload[pl_idx]
    always_comb begin
        if (state_q == STREAM) begin
            pl_rd_addr = pl_idx_q[LEN_W-1:0] + {{(LEN_W-1){1'b0}}, run_s};
        end else begin
            pl_rd_addr = '0;
        end
    end

    // Past the payload the encoder is fed zero flush bytes that are never emitted
    always_comb begin
        if (pl_idx_q < {1'b0, len_q}) begin
            enc_data_in = pl_rd_data;
        end else begin
            enc_data_in = '0;
        end
    end

    assign req_ready      = req_ready_q;
    assign req_err        = req_err_q;
    assign enc_sync_reset = sync_q;
    assign enc_run        = run_s;
    assign enc_type       = type_q;
    assign enc_code       = code_q;
    assign enc_checksum   = cksum_q;
    assign tx_data        = enc_data_out;
    assign tx_valid       = valid_q;
    assign tx_sop         = sop_q;
    assign tx_eop         = eop_q;

endmodule

// File: tb/tb_icmp_tx_sequencer8.sv
// Directed bench for icmp_tx_sequencer8 with a behavioural encoder and
// a 1-cycle-latency payload buffer.
module tb_icmp_tx_sequencer8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_reply_mode = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_type = 8'h00;
    logic [7:0]  req_code = 8'h00;
    logic [15:0] req_checksum = 16'h0000;
    logic [10:0] req_len = 11'd0;
    logic [10:0] pl_rd_addr;
    logic [7:0]  pl_rd_data;
    logic        enc_sync_reset;
    logic        enc_run;
    logic [7:0]  enc_type;
    logic [7:0]  enc_code;
    logic [15:0] enc_checksum;
    logic [7:0]  enc_data_in;
    logic [7:0]  enc_data_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_sop;
    logic        tx_eop;
    logic        tx_ready = 1'b1;
    logic        req_err;

    logic [7:0]  mem [0:2047];
    logic [7:0]  enc_sr [0:3];
    logic [7:0]  exp_b [0:63];
    int          n_chk = 0;
    int          n_err = 0;

    icmp_tx_sequencer8 dut (
        .clk(clk), .reset(reset), .cfg_reply_mode(cfg_reply_mode),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_code(req_code), .req_checksum(req_checksum), .req_len(req_len),
        .pl_rd_addr(pl_rd_addr), .pl_rd_data(pl_rd_data),
        .enc_sync_reset(enc_sync_reset), .enc_run(enc_run), .enc_type(enc_type),
        .enc_code(enc_code), .enc_checksum(enc_checksum), .enc_data_in(enc_data_in),
        .enc_data_out(enc_data_out), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_ready(tx_ready), .req_err(req_err)
    );

    always #5 clk = ~clk;

    // Payload buffer with one cycle of read latency
    always @(posedge clk) pl_rd_data <= mem[pl_rd_addr];

    // Encoder: load type/code/checksum, then shift one byte per run, data_in at the tail
    always @(posedge clk) begin
        if (enc_sync_reset) begin
            enc_sr[0] <= enc_type;
            enc_sr[1] <= enc_code;
            enc_sr[2] <= enc_checksum[15:8];
            enc_sr[3] <= enc_checksum[7:0];
        end else if (enc_run) begin
            enc_sr[0] <= enc_sr[1];
            enc_sr[1] <= enc_sr[2];
            enc_sr[2] <= enc_sr[3];
            enc_sr[3] <= enc_data_in;
        end
    end
    assign enc_data_out = enc_sr[0];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Fill payload and the expected emitted header (hand-computed) plus payload bytes
    task automatic prep(input logic [7:0] t, input logic [7:0] c, input logic [15:0] ck,
                        input int len, input int base, input int step);
        exp_b[0] = t;
        exp_b[1] = c;
        exp_b[2] = ck[15:8];
        exp_b[3] = ck[7:0];
        for (int i = 0; i < len; i++) begin
            mem[i]       = 8'(base + i * step);
            exp_b[4 + i] = mem[i];
        end
    endtask

    task automatic send_req(input logic [7:0] t, input logic [7:0] c, input logic [15:0] ck,
                            input logic [10:0] len, input logic mode);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) check_eq("req_ready_wait", req_ready, 1);
        req_valid = 1'b1; req_type = t; req_code = c; req_checksum = ck;
        req_len = len; cfg_reply_mode = mode;
        @(negedge clk);
        req_valid = 1'b0;
        cfg_reply_mode = ~mode;
    endtask

    task automatic run_frame(input int nbytes, input bit toggle);
        int         idx;
        int         cyc;
        bit         started;
        bit         stalled;
        logic [9:0] held;
        idx = 0; cyc = 0; started = 0; stalled = 0; held = '0;
        while (idx < nbytes && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (started) check_eq("valid_in_frame", tx_valid, 1);
            if (stalled) check_eq("stall_hold", {tx_sop, tx_eop, tx_data}, held);
            tx_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            stalled  = 0;
            if (tx_valid) begin
                if (tx_ready) begin
                    check_eq($sformatf("byte%0d", idx), tx_data, exp_b[idx]);
                    check_eq($sformatf("sop%0d", idx), tx_sop, idx == 0);
                    check_eq($sformatf("eop%0d", idx), tx_eop, idx == nbytes - 1);
                    idx++;
                    started = 1;
                end else begin
                    stalled = 1;
                    held    = {tx_sop, tx_eop, tx_data};
                end
            end
        end
        if (idx < nbytes) check_eq("frame_timeout", idx, nbytes);
        tx_ready = 1'b1;
        @(negedge clk);
        check_eq("valid_after_eop", tx_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) enc_sr[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_sop_eop", {tx_sop, tx_eop}, 0);
        check_eq("rst_enc_ctl", {enc_sync_reset, enc_run}, 0);
        check_eq("rst_req_err", req_err, 0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", req_ready, 1);

        // Echo request -> reply: ~fold(~F7FD + F7FF) = FFFD
        prep(8'h00, 8'h00, 16'hFFFD, 4, 1, 1);
        send_req(8'h08, 8'h00, 16'hF7FD, 11'd4, 1'b1);
        run_frame(8, 0);

        prep(8'h08, 8'h00, 16'hF7FD, 4, 1, 1);
        send_req(8'h08, 8'h00, 16'hF7FD, 11'd4, 1'b0);
        run_frame(8, 0);

        // ~(0800 + F7FF) = ~FFFF = 0000
        prep(8'h00, 8'h00, 16'h0000, 4, 8'h10, 1);
        send_req(8'h08, 8'h00, 16'hF7FF, 11'd4, 1'b1);
        run_frame(8, 0);

        // ~(0000 + F7FF) = 0800
        prep(8'h00, 8'h00, 16'h0800, 4, 8'h20, 1);
        send_req(8'h08, 8'h00, 16'hFFFF, 11'd4, 1'b1);
        run_frame(8, 0);

        // Non-echo type passes through verbatim even in reply mode
        prep(8'h0D, 8'h05, 16'h1234, 5, 8'hA0, 3);
        send_req(8'h0D, 8'h05, 16'h1234, 11'd5, 1'b1);
        run_frame(9, 0);

        // Backpressure: reply checksum 1234 + 0800 = 1A34
        prep(8'h00, 8'h00, 16'h1A34, 6, 8'h41, 5);
        send_req(8'h08, 8'h00, 16'h1234, 11'd6, 1'b1);
        run_frame(10, 1);

        // Short request rejected
        send_req(8'h08, 8'h00, 16'h0000, 11'd3, 1'b1);
        check_eq("req_err_pulse", req_err, 1);
        check_eq("req_err_no_valid", tx_valid, 0);
        @(negedge clk);
        check_eq("req_err_clear", req_err, 0);
        check_eq("req_err_no_load", {enc_sync_reset, tx_valid}, 0);
        check_eq("req_err_ready", req_ready, 1);
        prep(8'h00, 8'h00, 16'hABCD, 5, 8'h77, 1);
        send_req(8'h00, 8'h00, 16'hABCD, 11'd5, 1'b0);
        run_frame(9, 0);

        // Reset in the middle of a 24-byte frame
        prep(8'h08, 8'h00, 16'h1111, 20, 8'h01, 2);
        send_req(8'h08, 8'h00, 16'h1111, 11'd20, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("mid_byte%0d", i), tx_data, exp_b[i]);
        end
        reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", tx_valid, 0);
        check_eq("mid_rst_eop", tx_eop, 0);
        @(negedge clk);
        reset = 1'b0;
        prep(8'h00, 8'h00, 16'hFFFD, 4, 8'h55, 1);
        send_req(8'h08, 8'h00, 16'hF7FD, 11'd4, 1'b1);
        run_frame(8, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
